// File: rtl/reg_trace.sv
// reg_trace: register write-back trace and end-of-run register dump engine.
//
// Every regfile write (except r0) made while the processor runs is logged as
// {cycle, reg, data} into a first-word-fall-through event FIFO and streamed
// out through a valid/ready port. When the dump feature is built in
// (REG_TRACE_SCAN_EN defined), a dump request issued while the processor is
// stopped first drains the FIFO. It then takes over regfile read port A and
// emits all 32 register values in index order on the same output port.
//
// Parameters
//   DEPTH    event FIFO entries (power of two, 4..256)
//   CYCLE_W  width of the free-running cycle timestamp
// Ports
//   clock, reset         clock, asynchronous active-low reset
//   run                  processor running; gates counter and capture
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg   regfile write tap
//   dump_start           one-cycle dump request
//   scan_active          dump owns read port A (top muxes ctrl_readRegA)
//   scan_readReg         register index driven onto read port A
//   scan_data            combinational data_readRegA from the regfile
//   out_valid/out_ready  output beat handshake
//   out_kind             0 = write event, 1 = dump beat
//   out_cycle, out_reg, out_data   beat payload
//   overflow, dropped    sticky drop flag, saturating drop count
// Build option: REG_TRACE_SCAN_EN compiles in the dump FSM and scan port.
module reg_trace #(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               ctrl_writeEnable,
    input  logic [4:0]         ctrl_writeReg,
    input  logic [31:0]        data_writeReg,
    input  logic               dump_start,
    output logic               scan_active,
    output logic [4:0]         scan_readReg,
    input  logic [31:0]        scan_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_kind,
    output logic [CYCLE_W-1:0] out_cycle,
    output logic [4:0]         out_reg,
    output logic [31:0]        out_data,
    output logic               overflow,
    output logic [7:0]         dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CYCLE_W + 5 + 32;

    logic [CYCLE_W-1:0] cnt_q, cnt_d;
    logic [AW:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic               ovf_q, ovf_d;
    logic [7:0]         drop_q, drop_d;
    logic [EW-1:0]      mem_q [DEPTH];
    logic [EW-1:0]      head;

    logic empty, full, fifo_out_en, fifo_valid;
    logic push_req, push, pop, drop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        push_req   = run && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        fifo_valid = fifo_out_en && !empty;
        pop        = fifo_valid && out_ready;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        cnt_d      = run ? cnt_q + 1'b1 : cnt_q;
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        ovf_d      = ovf_q | drop;
        drop_d     = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Event storage is data only; validity comes from the pointers.
    always_ff @(posedge clock) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= {cnt_q, ctrl_writeReg, data_writeReg};
    end

    assign overflow = ovf_q;
    assign dropped  = drop_q;

`ifdef REG_TRACE_SCAN_EN
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SCAN, S_HOLD} state_t;

    state_t      state_q;
    logic [4:0]  idx_q;
    logic        scan_q;
    logic [31:0] hold_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            scan_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  if (dump_start && !run) state_q <= S_DRAIN;
                S_DRAIN: if (empty) begin
                    state_q <= S_SCAN;
                    scan_q  <= 1'b1;
                end
                S_SCAN:  state_q <= S_HOLD;
                S_HOLD:  if (out_ready) begin
                    if (idx_q == 5'd31) begin
                        idx_q   <= '0;
                        state_q <= S_IDLE;
                        scan_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 5'd1;
                        state_q <= S_SCAN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Register value is captured once so the beat stays stable under backpressure.
    always_ff @(posedge clock) begin
        if (state_q == S_SCAN) hold_q <= scan_data;
    end

    assign fifo_out_en  = (state_q == S_IDLE) || (state_q == S_DRAIN);
    assign scan_active  = scan_q;
    assign scan_readReg = idx_q;

    always_comb begin
        out_valid = 1'b0;
        out_kind  = 1'b0;
        out_cycle = '0;
        out_reg   = '0;
        out_data  = '0;
        if (state_q == S_HOLD) begin
            out_valid = 1'b1;
            out_kind  = 1'b1;
            out_reg   = idx_q;
            out_data  = hold_q;
        end else if (fifo_valid) begin
            out_valid = 1'b1;
            out_cycle = head[EW-1 -: CYCLE_W];
            out_reg   = head[36:32];
            out_data  = head[31:0];
        end
    end
`else
    logic unused_scan;
    assign unused_scan  = ^{dump_start, scan_data};
    assign fifo_out_en  = 1'b1;
    assign scan_active  = 1'b0;
    assign scan_readReg = 5'd0;

    always_comb begin
        out_valid = fifo_valid;
        out_kind  = 1'b0;
        out_cycle = '0;
        out_reg   = '0;
        out_data  = '0;
        if (fifo_valid) begin
            out_cycle = head[EW-1 -: CYCLE_W];
            out_reg   = head[36:32];
            out_data  = head[31:0];
        end
    end
`endif
endmodule
